spike_trace_lv_bank: RTL and testbench

- Bank of the two per-lane state elements used by the online training block.
- p_n level-value registers: each captures a neuron's state value (threshold-width) on that neuron's output-spike rising edge.
- p_s synaptic tracers: each is set to full scale on an input-event rising edge, then decays linearly every clock.
- The trainer reads the level values for threshold adaptation and samples the traces for weight updates.

---
 rtl/spike_trace_lv_bank.sv | 89 ++++++++
 tb/tb_spike_trace_lv_bank.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_trace_lv_bank.sv
// Per-lane state bank for online training: level-value capture and linear-decay synaptic traces.
// Latency: one clock from a spike/event rising edge to the updated o_lv / o_trace lane.
// Backpressure: none; every input is sampled on every rising edge and outputs are always valid.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        synchronous active-low reset, overrides every other update
//   i_lvl_spikeout p_n neuron output spikes (level), bit i-1 = neuron i
//   i_sv           p_n neuron state values, lane i at [i*p_thr_width-1 -: p_thr_width]
//   i_syncout      p_s input events (level), bit i-1 = synapse i
//   o_lv           latched level values, same lane packing as i_sv
//   o_trace        trace values, lane i at [i*p_width-1 -: p_width]
module spike_trace_lv_bank #(
  parameter int unsigned p_width  = 8,
  parameter int unsigned p_resbit = 8,
  parameter int unsigned p_n      = 8,
  parameter int unsigned p_s      = 42,
  parameter int unsigned p_decay  = 1,
  localparam int unsigned p_thr_width = p_width + p_resbit + 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [p_n-1:0]             i_lvl_spikeout,
  input  logic [p_n*p_thr_width-1:0] i_sv,
  input  logic [p_s-1:0]             i_syncout,
  output logic [p_n*p_thr_width-1:0] o_lv,
  output logic [p_s*p_width-1:0]     o_trace
);

  localparam logic [p_width-1:0] c_full = '1;
  // A decay larger than the trace range never satisfies the >= test, so the
  // truncated constant is only ever used when it is exact.
  localparam logic [p_width-1:0] c_dec  = p_width'(p_decay);

  logic [p_n-1:0]             spk_hist_q, spk_hist_d;
  logic [p_s-1:0]             evt_hist_q, evt_hist_d;
  logic [p_n*p_thr_width-1:0] lv_q, lv_d;
  logic [p_s*p_width-1:0]     trace_q, trace_d;

  logic [p_n-1:0] spk_rise;
  logic [p_s-1:0] evt_rise;

  // History is cleared on reset, so an input already high after release is a rise.
  assign spk_rise = i_lvl_spikeout & ~spk_hist_q;
  assign evt_rise = i_syncout & ~evt_hist_q;

  always_comb begin
    spk_hist_d = i_lvl_spikeout;
    evt_hist_d = i_syncout;
    lv_d       = lv_q;
    trace_d    = '0;

    for (int i = 0; i < int'(p_n); i++) begin
      if (spk_rise[i]) begin
        lv_d[i*p_thr_width +: p_thr_width] = i_sv[i*p_thr_width +: p_thr_width];
      end
    end

    // A rise always reloads full scale, even over a partially decayed value;
    // otherwise decay linearly and saturate at zero.
    for (int i = 0; i < int'(p_s); i++) begin
      if (evt_rise[i]) begin
        trace_d[i*p_width +: p_width] = c_full;
      end else if (32'(trace_q[i*p_width +: p_width]) >= p_decay) begin
        trace_d[i*p_width +: p_width] = trace_q[i*p_width +: p_width] - c_dec;
      end else begin
        trace_d[i*p_width +: p_width] = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      spk_hist_q <= '0;
      evt_hist_q <= '0;
      lv_q       <= '0;
      trace_q    <= '0;
    end else begin
      spk_hist_q <= spk_hist_d;
      evt_hist_q <= evt_hist_d;
      lv_q       <= lv_d;
      trace_q    <= trace_d;
    end
  end

  assign o_lv    = lv_q;
  assign o_trace = trace_q;

endmodule

// File: tb/tb_spike_trace_lv_bank.sv
module tb_spike_trace_lv_bank;

  localparam int W  = 8;
  localparam int TW = 22;
  localparam int N  = 8;
  localparam int S  = 42;
  localparam int DEC = 1;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     spk;
  logic [N*TW-1:0]  sv;
  logic [S-1:0]     evt;
  logic [N*TW-1:0]  lv;
  logic [S*W-1:0]   trace;

  int checks;
  int failures;

  spike_trace_lv_bank dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_lvl_spikeout (spk),
    .i_sv           (sv),
    .i_syncout      (evt),
    .o_lv           (lv),
    .o_trace        (trace)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Level values: last value captured on a rise. Traces: derived from the edge
  // index of the most recent event rise (-1 = none since reset).
  logic [TW-1:0] m_lv   [N];
  longint        m_last [S];
  logic [N-1:0]  m_prev_spk;
  logic [S-1:0]  m_prev_evt;
  longint        m_edge;

  logic [N*TW-1:0] q_lv    [$];
  logic [S*W-1:0]  q_trace [$];

  function automatic logic [W-1:0] trace_of(longint last, longint now);
    longint v;
    if (last < 0) return '0;
    v = 255 - (now - last) * DEC;
    if (v < 0) v = 0;
    return W'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_lv[i] = '0;
    for (int i = 0; i < S; i++) m_last[i] = -1;
    m_prev_spk = '0;
    m_prev_evt = '0;
  endtask

  task automatic model_edge();
    logic [N*TW-1:0] e_lv;
    logic [S*W-1:0]  e_tr;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++)
        if (spk[i] && !m_prev_spk[i]) m_lv[i] = sv[i*TW +: TW];
      for (int i = 0; i < S; i++)
        if (evt[i] && !m_prev_evt[i]) m_last[i] = m_edge;
      m_prev_spk = spk;
      m_prev_evt = evt;
    end
    for (int i = 0; i < N; i++) e_lv[i*TW +: TW] = m_lv[i];
    for (int i = 0; i < S; i++) e_tr[i*W +: W] = trace_of(m_last[i], m_edge);
    q_lv.push_back(e_lv);
    q_trace.push_back(e_tr);
    m_edge++;
  endtask

  // One clock edge; inputs are changed by the caller 1 time unit after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s at t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (q_lv.size() > 0) begin
      chk("o_lv", 512'(lv), 512'(q_lv.pop_front()));
      chk("o_trace", 512'(trace), 512'(q_trace.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    failures = 0;
    m_edge = 0;
    model_reset();

    // Reset with busy inputs
    rst_n = 1'b0;
    spk = '1;
    evt = '1;
    for (int i = 0; i < N; i++) sv[i*TW +: TW] = TW'($urandom);
    step(); step();
    rst_n = 1'b1; spk = '0; evt = '0; sv = '0;
    step(); step();
    #1;
    chk("reset_lv_zero", 512'(lv), 512'(0));
    chk("reset_trace_zero", 512'(trace), 512'(0));

    // LV capture on lane 3
    sv[2*TW +: TW] = 22'h12345;
    spk[2] = 1'b1;
    step();
    spk[2] = 1'b0;
    sv[2*TW +: TW] = 22'h0AAAA;
    #1;
    chk("lv3_capture", 512'(lv[2*TW +: TW]), 512'(22'h12345));
    step(); step(); step();
    #1;
    chk("lv3_hold", 512'(lv[2*TW +: TW]), 512'(22'h12345));

    // Held spike on lane 1: only the first edge captures
    spk[0] = 1'b1;
    sv[0 +: TW] = 22'h00BEEF;
    for (int k = 0; k < 5; k++) begin
      step();
      sv[0 +: TW] = TW'($urandom);
    end
    spk[0] = 1'b0;
    step();
    #1;
    chk("lv1_held", 512'(lv[0 +: TW]), 512'(22'h00BEEF));

    // Trace decay to zero on lane 1
    evt[0] = 1'b1;
    step();
    evt[0] = 1'b0;
    #1;
    chk("trace1_full", 512'(trace[0 +: W]), 512'(8'hFF));
    step();
    #1;
    chk("trace1_fe", 512'(trace[0 +: W]), 512'(8'hFE));
    for (int k = 0; k < 270; k++) step();
    #1;
    chk("trace1_floor", 512'(trace[0 +: W]), 512'(8'h00));

    // Retrigger on lane 5
    evt[4] = 1'b1;
    step();
    evt[4] = 1'b0;
    for (int k = 0; k < 9; k++) step();
    #1;
    chk("trace5_f6", 512'(trace[4*W +: W]), 512'(8'hF6));
    evt[4] = 1'b1;
    step();
    evt[4] = 1'b0;
    #1;
    chk("trace5_reload", 512'(trace[4*W +: W]), 512'(8'hFF));
    chk("trace6_idle", 512'(trace[5*W +: W]), 512'(8'h00));

    // Priority: rise together with reset; release with lane 2 event held high
    evt[3] = 1'b1;
    evt[1] = 1'b1;
    rst_n = 1'b0;
    step();
    #1;
    chk("prio_trace4_zero", 512'(trace[3*W +: W]), 512'(8'h00));
    evt[3] = 1'b0;
    rst_n = 1'b1;
    step();
    #1;
    chk("release_trace2_full", 512'(trace[1*W +: W]), 512'(8'hFF));
    step(); step();
    evt[1] = 1'b0;

    // Randomized phase, including occasional reset asserted mid-cycle
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        spk[i] = ($urandom_range(0, 3) == 0);
        sv[i*TW +: TW] = TW'($urandom);
      end
      for (int i = 0; i < S; i++) evt[i] = ($urandom_range(0, 15) == 0);
      step();
    end
    rst_n = 1'b1;

    @(negedge clk);
    #1;
    chk("queue_drained", 512'(q_lv.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
